// File: rtl/mux_pkg.sv
// Shared definitions for the mux_4to1 serializer slice.
//   SEL_W / DATA_W : select and word widths of the 4:1 mux
//   state_t        : sequencer state encoding (IDLE / SHIFT, 1 bit)
//   sel_of()       : maps a bit index to a mux select for either bit order
package mux_pkg;

    localparam int SEL_W  = 2;
    localparam int DATA_W = 4;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_t;

    // LSB-first walks the select upwards, MSB-first walks it downwards.
    function automatic logic [SEL_W-1:0] sel_of(input logic [SEL_W-1:0] idx,
                                                input logic             msb_first);
        return msb_first ? (SEL_W'(DATA_W - 1) - idx) : idx;
    endfunction

endpackage

// File: rtl/mux_4to1_serializer_if.sv
// Bus bundle between a word producer / serial consumer and the serializer.
//   in_data, in_valid, in_ready : parallel word handshake
//   ser_data, ser_valid         : serial bit and its qualifier
//   ser_first, ser_last         : frame markers for bit 0 and bit 3
//   sel_dbg                     : current mux select
//   busy                        : active word or pending word held
// Modports: master = producer/consumer side, slave = serializer side.
interface mux_4to1_serializer_if;
    import mux_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ser_data;
    logic              ser_valid;
    logic              ser_first;
    logic              ser_last;
    logic [SEL_W-1:0]  sel_dbg;
    logic              busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_data, ser_valid, ser_first, ser_last, sel_dbg, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_data, ser_valid, ser_first, ser_last, sel_dbg, busy
    );

endinterface

// File: rtl/mux_4to1.sv
// Plain 4:1 multiplexer.
//   a : four data inputs (one per select position)
//   s : select
//   y : a[s]
module mux_4to1
    import mux_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [SEL_W-1:0]  s,
    output logic              y
);

    assign y = a[s];

endmodule

// File: rtl/mux_4to1_serializer.sv
// Sequencer that feeds a mux_4to1 and steps its select so that y becomes a
// framed serial bitstream. A one-entry pending buffer lets a second word wait
// behind the active one, so consecutive words are sent with no idle gap.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave modport of mux_4to1_serializer_if (handshake + serial out)
// Parameters:
//   BIT_CYCLES : clocks each bit is held (>= 1)
//   MSB_FIRST  : 0 = select order 0,1,2,3; 1 = select order 3,2,1,0
module mux_4to1_serializer
    import mux_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter int MSB_FIRST  = 0
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    mux_4to1_serializer_if.slave   bus
);

    localparam int                TICK_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_CYCLES - 1);
    localparam logic [SEL_W-1:0]  IDX_LAST  = SEL_W'(DATA_W - 1);
    localparam logic              MSB       = (MSB_FIRST != 0);

    state_t            state;
    logic [DATA_W-1:0] act_word;
    logic [DATA_W-1:0] pend_word;
    logic              pend_full;
    logic              rdy;
    logic [SEL_W-1:0]  idx;
    logic [TICK_W-1:0] tick;

    logic              accept;
    logic              tick_end;
    logic              word_end;
    logic              shifting;
    logic [SEL_W-1:0]  sel;
    logic              mux_y;

    assign accept   = bus.in_valid && rdy;
    assign shifting = (state == SHIFT);
    assign tick_end = (tick == TICK_LAST);
    assign word_end = shifting && (idx == IDX_LAST) && tick_end;

    // Control FSM. rdy is a register mirroring !pend_full so that in_ready is
    // held low through reset and rises only at the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend_full <= 1'b0;
            rdy       <= 1'b0;
            idx       <= '0;
            tick      <= '0;
        end else begin
            rdy <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= SHIFT;
                        idx   <= '0;
                        tick  <= '0;
                    end
                end
                SHIFT: begin
                    if (!word_end) begin
                        if (tick_end) begin
                            tick <= '0;
                            idx  <= idx + 1'b1;
                        end else begin
                            tick <= tick + 1'b1;
                        end
                        if (accept) begin
                            pend_full <= 1'b1;
                        end
                        rdy <= !(pend_full || accept);
                    end else begin
                        idx  <= '0;
                        tick <= '0;
                        if (pend_full) begin
                            pend_full <= 1'b0;
                        end else if (!accept) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word storage carries no reset: it is only observed while state is SHIFT.
    // A word arriving exactly at end of word with nothing pending bypasses
    // the pending buffer and becomes active directly.
    always_ff @(posedge clk) begin
        if (accept && (!shifting || (word_end && !pend_full))) begin
            act_word <= bus.in_data;
        end else if (word_end && pend_full) begin
            act_word <= pend_word;
        end
        if (accept && shifting && !word_end) begin
            pend_word <= bus.in_data;
        end
    end

    assign sel = shifting ? sel_of(idx, MSB) : '0;

    mux_4to1 u_mux (
        .a (act_word),
        .s (sel),
        .y (mux_y)
    );

    // All outputs are decoded from registered state only.
    assign bus.in_ready  = rdy;
    assign bus.ser_valid = shifting;
    assign bus.ser_data  = mux_y & shifting;
    assign bus.ser_first = shifting && (idx == '0);
    assign bus.ser_last  = shifting && (idx == IDX_LAST);
    assign bus.sel_dbg   = sel;
    assign bus.busy      = shifting || pend_full;

endmodule

// File: tb/tb_mux_4to1_serializer.sv
// Self-checking bench for mux_4to1_serializer. Three instances cover the
// bit-order and bit-duration variants; a reference model expands every
// accepted word into its expected per-cycle serial samples and checks each
// cycle's outputs against the head of that sample queue.
module tb_mux_4to1_serializer;

    typedef struct packed {
        logic       b;
        logic       f;
        logic       l;
        logic [1:0] s;
    } samp_t;

    logic clk;
    logic rst_n;

    mux_4to1_serializer_if if0 ();
    mux_4to1_serializer_if if1 ();
    mux_4to1_serializer_if if2 ();

    mux_4to1_serializer #(.BIT_CYCLES(1), .MSB_FIRST(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mux_4to1_serializer #(.BIT_CYCLES(1), .MSB_FIRST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mux_4to1_serializer #(.BIT_CYCLES(3), .MSB_FIRST(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int    checks = 0;
    int    errors = 0;
    samp_t q[$];
    bit    rdy_ok = 0;
    logic [3:0] wq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int bc_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic bit msb_of(input int d);
        return (d == 1);
    endfunction

    function automatic bit model_ready(input int d);
        return rdy_ok && (q.size() <= 4 * bc_of(d));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [3:0] dat);
        case (d)
            0:       begin if0.in_valid = v; if0.in_data = dat; end
            1:       begin if1.in_valid = v; if1.in_data = dat; end
            default: begin if2.in_valid = v; if2.in_data = dat; end
        endcase
    endtask

    // {in_ready, ser_valid, ser_data, ser_first, ser_last, busy, sel_dbg}
    function automatic logic [7:0] get_obs(input int d);
        case (d)
            0:       return {if0.in_ready, if0.ser_valid, if0.ser_data, if0.ser_first,
                             if0.ser_last, if0.busy, if0.sel_dbg};
            1:       return {if1.in_ready, if1.ser_valid, if1.ser_data, if1.ser_first,
                             if1.ser_last, if1.busy, if1.sel_dbg};
            default: return {if2.in_ready, if2.ser_valid, if2.ser_data, if2.ser_first,
                             if2.ser_last, if2.busy, if2.sel_dbg};
        endcase
    endfunction

    task automatic check_cycle(input int d);
        logic [7:0] o;
        samp_t      h;
        bit         act;
        o   = get_obs(d);
        act = (q.size() > 0);
        h   = act ? q[0] : '0;
        chk($sformatf("d%0d in_ready", d),  o[7],   model_ready(d));
        chk($sformatf("d%0d ser_valid", d), o[6],   act);
        chk($sformatf("d%0d ser_data", d),  o[5],   h.b);
        chk($sformatf("d%0d ser_first", d), o[4],   h.f);
        chk($sformatf("d%0d ser_last", d),  o[3],   h.l);
        chk($sformatf("d%0d busy", d),      o[2],   act);
        chk($sformatf("d%0d sel_dbg", d),   o[1:0], h.s);
    endtask

    // Expand a word into 4 bits, each held for BIT_CYCLES samples.
    task automatic push_word(input int d, input logic [3:0] w);
        samp_t sm;
        for (int i = 0; i < 4; i++) begin
            sm.s = msb_of(d) ? 2'(3 - i) : 2'(i);
            sm.b = w[sm.s];
            sm.f = (i == 0);
            sm.l = (i == 3);
            for (int k = 0; k < bc_of(d); k++) q.push_back(sm);
        end
    endtask

    task automatic edge_update(input int d, input bit acc, input logic [3:0] w);
        if (!rst_n) begin
            q.delete();
            rdy_ok = 0;
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (acc) push_word(d, w);
            rdy_ok = 1;
        end
    endtask

    // Offer the words of wq to instance d, one cycle per loop, checking
    // every cycle. gaps inserts random idle cycles; reset_at pulses rst_n.
    task automatic run(input int d, input bit gaps, input int reset_at);
        int         wi;
        int         cyc;
        bit         v;
        bit         acc;
        logic [3:0] dat;
        wi  = 0;
        cyc = 0;
        while (!(wi == wq.size() && q.size() == 0 && rst_n === 1'b1) && cyc < 2000) begin
            check_cycle(d);
            rst_n = (cyc == reset_at) ? 1'b0 : 1'b1;
            v     = (wi < wq.size()) && (!gaps || $urandom_range(0, 2) != 0);
            dat   = v ? wq[wi] : 4'($urandom);
            drive(d, v, dat);
            acc   = rst_n && v && model_ready(d);
            @(posedge clk);
            edge_update(d, acc, dat);
            if (acc) wi++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        assert (cyc < 2000) else begin
            errors++;
            $error("FAIL d%0d drain: observed %0d cycles, required fewer than 2000", d, cyc);
        end
        drive(d, 1'b0, 4'h0);
        check_cycle(d);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 4'h0);
        drive(1, 1'b0, 4'h0);
        drive(2, 1'b0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_cycle(d);
        rst_n = 1'b1;
        @(posedge clk);
        rdy_ok = 1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_cycle(d);

        // LSB first, one cycle per bit
        wq.delete(); wq.push_back(4'b0110);
        run(0, 0, -1);

        // MSB first
        wq.delete(); wq.push_back(4'b1101);
        run(1, 0, -1);

        // back-to-back words with in_valid held
        wq.delete(); wq.push_back(4'b0101); wq.push_back(4'b1101);
        run(0, 0, -1);

        // each bit held three cycles
        wq.delete(); wq.push_back(4'b0110);
        run(2, 0, -1);

        // reset during bit 2 with a pending word, then a clean word
        wq.delete(); wq.push_back(4'b1010); wq.push_back(4'b0111);
        run(0, 0, 3);
        wq.delete(); wq.push_back(4'b0011);
        run(0, 0, -1);

        // random words with random idle gaps on every variant
        for (int d = 0; d < 3; d++) begin
            wq.delete();
            for (int n = 0; n < 8; n++) wq.push_back(4'($urandom));
            run(d, 1, -1);
            wq.delete();
            for (int n = 0; n < 5; n++) wq.push_back(4'($urandom));
            run(d, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
